spi_exe_master: RTL and testbench

SPI initiator (CPOL=0) that drives one transaction to the execution-unit SPI responder.
- TX phase: three parallel bytes are serialised on MOSI, MSB first: argument A, then argument B, then the operation byte.
- RX phase: the 28-bit response on MISO is captured and split into an 8-bit result, 4 flags and a 16-bit zero pad.
- The block sits in the host-side logic and turns a start pulse into one complete chip-select framed transfer.
- It presents the result and flags with a done pulse.

---
 rtl/spi_exe_master.sv | 216 +++++++++++++++++++++
 tb/tb_spi_exe_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_exe_master.sv
// SPI initiator (CPOL=0) that runs one framed transfer to the execution-unit responder.
// It shifts out {argA, argB, oper} MSB first, waits TURN_BITS turnaround periods,
// then captures a RX_BITS response that is split into result, flags and pad.
module spi_exe_master #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned TX_BITS   = 24,
    parameter int unsigned TURN_BITS = 1,
    parameter int unsigned RX_BITS   = 28
) (
    input  logic       i_clk_p,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_argA,
    input  logic [7:0] i_argB,
    input  logic [7:0] i_oper,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result,
    output logic [3:0] o_flags,
    output logic       o_err
);

    localparam int unsigned N_BITS   = TX_BITS + TURN_BITS + RX_BITS;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W    = $clog2(N_BITS + 1);
    localparam int unsigned RX_START = TX_BITS + TURN_BITS;
    localparam int unsigned PAD_W    = RX_BITS - 12;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     bit_q, bit_d;
    logic [TX_BITS-2:0]   tx_q, tx_d;
    logic [RX_BITS-1:0]   rx_q, rx_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [7:0]           result_q, result_d;
    logic [3:0]           flags_q, flags_d;
    logic                 err_q, err_d;

    logic                 phase_end;
    logic                 start_ok;
    logic                 last_period;
    logic                 rx_period;
    logic                 tx_more;
    logic [TX_BITS-1:0]   tx_load;

    assign phase_end   = (div_q == DIV_W'(CLK_DIV - 1));
    // A start in the done cycle is dropped so frames are separated by two CS-high cycles.
    assign start_ok    = (state_q == IDLE) && i_start && !done_q;
    assign last_period = (bit_q == CNT_W'(N_BITS - 1));
    assign rx_period   = (bit_q >= CNT_W'(RX_START));
    assign tx_more     = (bit_q < CNT_W'(TX_BITS - 1));
    assign tx_load     = TX_BITS'({i_argA, i_argB, i_oper});

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk_p) begin
        if (i_rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    // Next state, phase divider and SCLK period counter
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = SHIFT;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (phase_end) begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Low phase of the final period is handled by HOLD
                        if (last_period) begin
                            state_d = HOLD;
                        end
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and shift registers
    always_comb begin
        tx_d     = tx_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_ok) begin
                    tx_d   = tx_load[TX_BITS-2:0];
                    rx_d   = '0;
                    mosi_d = tx_load[TX_BITS-1];
                    cs_n_d = 1'b0;
                    sclk_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    sclk_d = 1'b1;
                end
            end
            SHIFT: begin
                if (phase_end) begin
                    if (sclk_q) begin
                        // End of high phase: sample MISO, then present the next MOSI bit
                        sclk_d = 1'b0;
                        if (rx_period) begin
                            rx_d = {rx_q[RX_BITS-2:0], i_miso};
                        end
                        if (tx_more) begin
                            mosi_d = tx_q[TX_BITS-2];
                            tx_d   = {tx_q[TX_BITS-3:0], 1'b0};
                        end else begin
                            mosi_d = 1'b0;
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    cs_n_d   = 1'b1;
                    done_d   = 1'b1;
                    result_d = rx_q[RX_BITS-1 -: 8];
                    flags_d  = rx_q[RX_BITS-9 -: 4];
                    err_d    = |rx_q[PAD_W-1:0];
                end
            end
            default: ;
        endcase
    end

    assign o_sclk   = sclk_q;
    assign o_mosi   = mosi_q;
    assign o_cs_n   = cs_n_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = result_q;
    assign o_flags  = flags_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_spi_exe_master.sv
// Bench for spi_exe_master: default instance (CLK_DIV=2, TURN_BITS=1) and a fast
// instance (CLK_DIV=1, TURN_BITS=0), each with a behavioural SPI responder.
module tb_spi_exe_master;

    typedef struct {
        int unsigned dut;
        int unsigned done_cyc;
        logic [23:0] tx;
        int unsigned edges;
        logic [7:0]  res;
        logic [3:0]  flg;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [7:0]      arg_a, arg_b, oper;
    logic [1:0]      start, miso;
    logic [1:0]      sclk, mosi, cs_n, busy, done, err;
    logic [1:0][7:0] result;
    logic [1:0][3:0] flags;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [27:0] resp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    spi_exe_master #(.CLK_DIV(2), .TX_BITS(24), .TURN_BITS(1), .RX_BITS(28)) u_dut0 (
        .i_clk_p(clk), .i_rst(rst), .i_start(start[0]),
        .i_argA(arg_a), .i_argB(arg_b), .i_oper(oper), .i_miso(miso[0]),
        .o_sclk(sclk[0]), .o_mosi(mosi[0]), .o_cs_n(cs_n[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_result(result[0]), .o_flags(flags[0]), .o_err(err[0])
    );

    spi_exe_master #(.CLK_DIV(1), .TX_BITS(24), .TURN_BITS(0), .RX_BITS(28)) u_dut1 (
        .i_clk_p(clk), .i_rst(rst), .i_start(start[1]),
        .i_argA(arg_a), .i_argB(arg_b), .i_oper(oper), .i_miso(miso[1]),
        .o_sclk(sclk[1]), .o_mosi(mosi[1]), .o_cs_n(cs_n[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_result(result[1]), .o_flags(flags[1]), .o_err(err[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Responder, MOSI capture and scoreboard monitor, sampled on the falling edge
    initial begin
        int unsigned edges [2];
        logic [23:0] cap [2];
        logic [1:0]  prev_sclk;
        logic [1:0]  prev_cs;
        int          p, rs;
        exp_t        e;
        prev_sclk = '0;
        prev_cs   = '1;
        miso      = '0;
        for (int g = 0; g < 2; g++) begin
            edges[g] = 0;
            cap[g]   = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!cs_n[g] && prev_cs[g]) begin
                    edges[g] = 0;
                    cap[g]   = '0;
                end
                if (sclk[g] && !prev_sclk[g]) begin
                    check("cs_low_at_sclk_rise", 64'(cs_n[g]), 64'(0));
                    p  = int'(edges[g]);
                    rs = (g == 0) ? 25 : 24;
                    if (p < 24) cap[g] = {cap[g][22:0], mosi[g]};
                    if (p >= rs && p < rs + 28) miso[g] = resp[27 - (p - rs)];
                    else miso[g] = 1'b0;
                    edges[g]++;
                end
                if (done[g]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: dut%0d pulsed o_done at cycle %0d, want none", g, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_dut",   64'(g),         64'(e.dut));
                        check("done_cycle", 64'(cyc),       64'(e.done_cyc));
                        check("result",     64'(result[g]), 64'(e.res));
                        check("flags",      64'(flags[g]),  64'(e.flg));
                        check("err",        64'(err[g]),    64'(e.e));
                        check("mosi_stream", 64'(cap[g]),   64'(e.tx));
                        check("sclk_edges", 64'(edges[g]),  64'(e.edges));
                        check("busy_at_done", 64'({busy[g], cs_n[g]}), 64'(2'b11));
                    end
                end
                prev_sclk[g] = sclk[g];
                prev_cs[g]   = cs_n[g];
            end
        end
    end

    // Drive a start in the current cycle and queue the hand-computed response
    task automatic start_now(input int g, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [27:0] rsp,
                             input logic [7:0] xr, input logic [3:0] xf, input logic xe);
        exp_t e;
        arg_a    = a;
        arg_b    = b;
        oper     = op;
        resp     = rsp;
        start[g] = 1'b1;
        e.dut      = g;
        e.done_cyc = cyc + ((g == 0) ? 215 : 106);
        e.tx       = {a, b, op};
        e.edges    = (g == 0) ? 53 : 52;
        e.res      = xr;
        e.flg      = xf;
        e.e        = xe;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start[g] = 1'b0;
        check("busy_cs_after_start", 64'({busy[g], cs_n[g]}), 64'(2'b10));
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: %0d transfers still pending, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] outs(input int g);
        return {cs_n[g], sclk[g], mosi[g], busy[g], done[g], result[g], flags[g], err[g]};
    endfunction

    initial begin
        int unsigned i;
        rst   = 1'b1;
        start = '0;
        arg_a = '0;
        arg_b = '0;
        oper  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: CS high, SCLK low, everything else zero
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) check("idle_outputs", 64'(outs(g)), 64'({1'b1, 17'h0}));
        end

        // Basic frame and a frame with a non-zero pad
        start_now(0, 8'h12, 8'h34, 8'h10, 28'h4650000, 8'h46, 4'h5, 1'b0);
        wait_drain(400);
        start_now(0, 8'hA5, 8'h5A, 8'h30, 28'hFF0A001, 8'hFF, 4'h0, 1'b1);
        wait_drain(400);

        // Starts while busy and in the done cycle are dropped; done+1 is accepted
        start_now(0, 8'h0F, 8'hF0, 8'h20, 28'h1230000, 8'h12, 4'h3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        start[0] = 1'b1;
        arg_a = 8'hEE; arg_b = 8'hDD; oper = 8'hC0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        i = 0;
        while (!done[0] && i < 400) begin
            @(posedge clk); #1;
            i++;
        end
        check("done_seen", 64'(done[0]), 64'(1));
        start[0] = 1'b1;
        arg_a = 8'hEE; arg_b = 8'hDD; oper = 8'hC0;
        @(posedge clk); #1;
        start_now(0, 8'h77, 8'h88, 8'h40, 28'h8000000, 8'h80, 4'h0, 1'b0);
        repeat (99) @(posedge clk);
        #1;
        check("result_held", 64'({result[0], flags[0], err[0]}), 64'({8'h12, 4'h3, 1'b0}));
        wait_drain(400);

        // Reset in the middle of a frame aborts it without a done pulse
        start_now(0, 8'h12, 8'h34, 8'h10, 28'h4650000, 8'h46, 4'h5, 1'b0);
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_abort", 64'(outs(0)), 64'({1'b1, 17'h0}));
        repeat (300) @(posedge clk);
        #1;
        start_now(0, 8'h12, 8'h34, 8'h10, 28'h4650000, 8'h46, 4'h5, 1'b0);
        wait_drain(400);

        // Fastest divider, no turnaround
        start_now(1, 8'h12, 8'h34, 8'h10, 28'h4650000, 8'h46, 4'h5, 1'b0);
        wait_drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
